// File: rtl/barrel_pkg.sv
// barrel_pkg: op-code encodings shared by the pipelined barrel shifter and its stages.
package barrel_pkg;
    localparam int OP_W = 3;
    localparam logic [OP_W-1:0] OP_LSL = 3'd0;
    localparam logic [OP_W-1:0] OP_LSR = 3'd1;
    localparam logic [OP_W-1:0] OP_ASR = 3'd2;
    localparam logic [OP_W-1:0] OP_ROL = 3'd3;
    localparam logic [OP_W-1:0] OP_ROR = 3'd4;
endpackage

// File: rtl/barrel_stage.sv
// barrel_stage: one conditional shift-by-SHIFT level with carry update and an enabled pipeline register.
module barrel_stage
    import barrel_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHIFT = 1,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             carry_i,
    input  logic [OP_W-1:0]  op_i,
    input  logic [SHW-1:0]   amt_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             carry_o,
    output logic [OP_W-1:0]  op_o,
    output logic [SHW-1:0]   amt_o
);
    logic             hit;
    logic [WIDTH-1:0] data_d, data_q;
    logic             carry_d, carry_q, valid_q;
    logic [OP_W-1:0]  op_q;
    logic [SHW-1:0]   amt_q;

    assign hit = |(amt_i & SHW'(SHIFT));

    // Reserved ops fall through untouched; their carry stays at the 0 injected before stage 0.
    always_comb begin
        data_d  = data_i;
        carry_d = carry_i;
        if (hit) begin
            case (op_i)
                OP_LSL: begin
                    data_d  = data_i << SHIFT;
                    carry_d = data_i[WIDTH-SHIFT];
                end
                OP_LSR: begin
                    data_d  = data_i >> SHIFT;
                    carry_d = data_i[SHIFT-1];
                end
                OP_ASR: begin
                    data_d  = $signed(data_i) >>> SHIFT;
                    carry_d = data_i[SHIFT-1];
                end
                OP_ROL: begin
                    data_d  = (data_i << SHIFT) | (data_i >> (WIDTH-SHIFT));
                    carry_d = 1'b0;
                end
                OP_ROR: begin
                    data_d  = (data_i >> SHIFT) | (data_i << (WIDTH-SHIFT));
                    carry_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            carry_q <= 1'b0;
            op_q    <= '0;
            amt_q   <= '0;
        end else if (en_i) begin
            valid_q <= valid_i;
            data_q  <= data_d;
            carry_q <= carry_d;
            op_q    <= op_i;
            amt_q   <= amt_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign carry_o = carry_q;
    assign op_o    = op_q;
    assign amt_o   = amt_q;
endmodule

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: SHW-stage shift/rotate pipeline with carry-out and global-enable valid/ready flow control.
module pipelined_barrel_shifter
    import barrel_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [OP_W-1:0]  in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry
);
    logic             en;
    logic             v   [SHW+1];
    logic [WIDTH-1:0] d   [SHW+1];
    logic             c   [SHW+1];
    logic [OP_W-1:0]  op  [SHW+1];
    logic [SHW-1:0]   amt [SHW+1];

    // A stalled output freezes the whole pipe, bubbles included.
    assign en       = ~(out_valid & ~out_ready);
    assign in_ready = en;

    assign v[0]   = in_valid;
    assign d[0]   = in_data;
    assign c[0]   = 1'b0;
    assign op[0]  = in_op;
    assign amt[0] = in_amt;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        barrel_stage #(.WIDTH(WIDTH), .SHIFT(1 << k), .SHW(SHW)) u_stage (
            .clk    (clk),
            .rst    (rst),
            .en_i   (en),
            .valid_i(v[k]),
            .data_i (d[k]),
            .carry_i(c[k]),
            .op_i   (op[k]),
            .amt_i  (amt[k]),
            .valid_o(v[k+1]),
            .data_o (d[k+1]),
            .carry_o(c[k+1]),
            .op_o   (op[k+1]),
            .amt_o  (amt[k+1])
        );
    end

    assign out_valid = v[SHW];
    assign out_data  = d[SHW];
    assign out_carry = c[SHW];
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb_pipelined_barrel_shifter: scoreboard bench with directed vectors, streaming, backpressure, reset flush and random traffic.
module tb_pipelined_barrel_shifter;
    localparam int W   = 8;
    localparam int SHW = 3;

    typedef struct packed {
        logic [W-1:0] d;
        logic         c;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid, in_ready, out_valid, out_ready, out_carry;
    logic [W-1:0]   in_data, out_data;
    logic [SHW-1:0] in_amt;
    logic [2:0]     in_op;

    exp_t         q[$];
    int           n_asrt = 0;
    int           n_fail = 0;
    int           run = 0;
    int           run_max = 0;
    bit           rnd_bp = 0;
    logic         pstall = 0;
    logic [W-1:0] pd;
    logic         pc;

    pipelined_barrel_shifter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_amt   (in_amt),
        .in_op    (in_op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_carry(out_carry)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_asrt++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: whole-amount shift/rotate; carry is the single bit that left last.
    function automatic exp_t model(input logic [W-1:0] d, input logic [SHW-1:0] amt, input logic [2:0] op);
        exp_t         r;
        logic [W-1:0] rd;
        int           a;
        a   = int'(amt);
        rd  = d;
        r.c = 1'b0;
        case (op)
            3'd0: begin rd = d << a; if (a > 0) r.c = d[W-a]; end
            3'd1: begin rd = d >> a; if (a > 0) r.c = d[a-1]; end
            3'd2: begin
                for (int i = 0; i < W; i++) rd[i] = (i + a < W) ? d[i+a] : d[W-1];
                if (a > 0) r.c = d[a-1];
            end
            3'd3: for (int i = 0; i < W; i++) rd[(i+a)%W] = d[i];
            3'd4: for (int i = 0; i < W; i++) rd[i] = d[(i+a)%W];
            default: ;
        endcase
        r.d = rd;
        return r;
    endfunction

    task automatic send(input logic [W-1:0] d, input logic [SHW-1:0] amt, input logic [2:0] op,
                        input logic [W-1:0] ed, input logic ec);
        int   t = 0;
        exp_t e;
        e.d      = ed;
        e.c      = ec;
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = amt;
        in_op    = op;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("accept_timeout", in_ready, 1);
        else q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_m(input logic [W-1:0] d, input logic [SHW-1:0] amt, input logic [2:0] op);
        exp_t e;
        e = model(d, amt, op);
        send(d, amt, op, e.d, e.c);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (q.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        chk("drain_pending", q.size(), 0);
        #1;
    endtask

    task automatic check_latency();
        for (int i = 0; i < SHW; i++) begin
            @(negedge clk);
            chk("latency_valid", out_valid, (i == SHW - 1));
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            pstall = 1'b0;
            run    = 0;
        end else begin
            if (pstall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, pd);
                chk("hold_carry", out_carry, pc);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("spurious_beat", out_valid, 0);
                else begin
                    e = q.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_carry", out_carry, e.c);
                end
                run++;
                if (run > run_max) run_max = run;
            end else run = 0;
            if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
            pstall = out_valid & ~out_ready;
            pd     = out_data;
            pc     = out_carry;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_op     = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_carry", out_carry, 0);
        chk("reset_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        send(8'b1011_0011, 3'd3, 3'd0, 8'b1001_1000, 1'b1);
        check_latency();
        wait_drain();

        send(8'h96, 3'd2, 3'd2, 8'hE5, 1'b1);
        send(8'h96, 3'd2, 3'd1, 8'h25, 1'b1);
        send(8'h96, 3'd7, 3'd2, 8'hFF, 1'b0);
        send(8'h81, 3'd1, 3'd4, 8'hC0, 1'b0);
        send(8'h81, 3'd4, 3'd3, 8'h18, 1'b0);
        for (int o = 0; o < 8; o++) send(8'hA5, 3'd0, 3'(o), 8'hA5, 1'b0);
        send(8'h5C, 3'd3, 3'd5, 8'h5C, 1'b0);
        send(8'h80, 3'd7, 3'd1, 8'h01, 1'b0);
        send(8'h01, 3'd7, 3'd0, 8'h80, 1'b0);
        wait_drain();
        idle(2);

        run_max = 0;
        for (int i = 0; i < 8; i++) send_m(W'($urandom), SHW'($urandom), 3'($urandom_range(0, 4)));
        wait_drain();
        chk("stream_consecutive", run_max, 8);
        idle(2);

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_m(W'($urandom), SHW'($urandom), 3'($urandom_range(0, 4)));
        repeat (4) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_m(W'($urandom), SHW'($urandom), 3'($urandom_range(0, 4)));
        wait_drain();
        idle(2);

        send_m(8'h3C, 3'd1, 3'd0);
        send_m(8'hC3, 3'd2, 3'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        send(8'hF0, 3'd4, 3'd4, 8'h0F, 1'b0);
        check_latency();
        wait_drain();
        idle(3);

        rnd_bp = 1;
        fork
            while (rnd_bp) begin
                @(posedge clk);
                #1;
                out_ready = ($urandom_range(0, 3) != 0);
            end
        join_none
        for (int i = 0; i < 300; i++) begin
            send_m(W'($urandom), SHW'($urandom), 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        rnd_bp = 0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        wait_drain();
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
